// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states and the memory arbiter FSM encoding.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        DONE_I  = 3'd3,
        DONE_D  = 3'd4,
        FAULT   = 3'd5
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access, one transaction at a time.
// Data has priority; a burst counter forces a fetch grant, and a watchdog faults a stuck RAM.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DBURST = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int DB_W   = $clog2(MAX_DBURST + 1);

    arb_state_t        state_q,    state_d;
    logic [WAIT_W-1:0] wait_q,     wait_d;
    logic [DB_W-1:0]   dburst_q,   dburst_d;
    logic              ihit_q,     ihit_d;
    logic              dhit_q,     dhit_d;
    logic [31:0]       iload_q,    iload_d;
    logic [31:0]       dload_q,    dload_d;
    logic              ramREN_q,   ramREN_d;
    logic              ramWEN_q,   ramWEN_d;
    logic [31:0]       ramaddr_q,  ramaddr_d;
    logic [31:0]       ramstore_q, ramstore_d;
    logic              err_q,      err_d;

    ramstate_t ram_st;
    logic      d_req;
    logic      timed_out;

    assign ram_st    = ramstate_t'(ramstate);
    assign d_req     = dREN | dWEN;
    assign timed_out = (wait_q == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every next-state value gets its hold default first so no path infers a latch.
        state_d    = state_q;
        wait_d     = wait_q;
        dburst_d   = dburst_q;
        ihit_d     = 1'b0;
        dhit_d     = 1'b0;
        iload_d    = iload_q;
        dload_d    = dload_q;
        ramREN_d   = ramREN_q;
        ramWEN_d   = ramWEN_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (d_req && (dburst_q < DB_W'(MAX_DBURST))) begin
                    state_d    = GRANT_D;
                    wait_d     = '0;
                    ramaddr_d  = daddr;
                    ramstore_d = dstore;
                    ramWEN_d   = dWEN;
                    ramREN_d   = ~dWEN;
                end else if (iREN) begin
                    state_d    = GRANT_I;
                    wait_d     = '0;
                    ramaddr_d  = iaddr;
                    ramstore_d = dstore;
                    ramWEN_d   = 1'b0;
                    ramREN_d   = 1'b1;
                end
            end
            GRANT_I, GRANT_D: begin
                if (ram_st == ACCESS) begin
                    ramREN_d = 1'b0;
                    ramWEN_d = 1'b0;
                    if (state_q == GRANT_I) begin
                        iload_d = ramload;
                        ihit_d  = 1'b1;
                        state_d = DONE_I;
                    end else begin
                        if (ramREN_q) dload_d = ramload;
                        dhit_d  = 1'b1;
                        state_d = DONE_D;
                    end
                end else if ((ram_st == ERROR) || timed_out) begin
                    // Release the requester with a zero result so it cannot hang on a dead RAM.
                    ramREN_d = 1'b0;
                    ramWEN_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = FAULT;
                    if (state_q == GRANT_I) begin
                        iload_d = '0;
                        ihit_d  = 1'b1;
                    end else begin
                        dload_d = '0;
                        dhit_d  = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DONE_I, DONE_D, FAULT: state_d = IDLE;
            default:               state_d = IDLE;
        endcase

        if ((state_q == IDLE) && (state_d == GRANT_D) && iREN) begin
            if (dburst_q != DB_W'(MAX_DBURST)) dburst_d = dburst_q + DB_W'(1);
        end else if (((state_q == IDLE) && (state_d == GRANT_I)) || !iREN) begin
            dburst_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous; sequential state uses non-blocking assignments only.
        if (RST) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            dburst_q   <= '0;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            iload_q    <= '0;
            dload_q    <= '0;
            ramREN_q   <= 1'b0;
            ramWEN_q   <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            dburst_q   <= dburst_d;
            ihit_q     <= ihit_d;
            dhit_q     <= dhit_d;
            iload_q    <= iload_d;
            dload_q    <= dload_d;
            ramREN_q   <= ramREN_d;
            ramWEN_q   <= ramWEN_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
            err_q      <= err_d;
        end
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramREN   = ramREN_q;
    assign ramWEN   = ramWEN_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, starvation, write, watchdog, reset and RAM error.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        ihit, dhit, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.MAX_DBURST(4), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        tick(); tick();
        checks++;
        if ({ihit, dhit, ramREN, ramWEN, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000", {ihit, dhit, ramREN, ramWEN, err});
        end
        checks++;
        if ({iload, dload} !== 64'h0) begin
            failures++;
            $display("FAIL reset_loads: iload=%h dload=%h expected 0", iload, dload);
        end
        checks++;
        if ({ramaddr, ramstore} !== 64'h0) begin
            failures++;
            $display("FAIL reset_ram: ramaddr=%h ramstore=%h expected 0", ramaddr, ramstore);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_fetch_only();
        int early = 0;
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
        tick();
        checks++;
        if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin
            failures++;
            $display("FAIL fetch_grant: ramREN=%b ramWEN=%b ramaddr=%h expected 1 0 00000040", ramREN, ramWEN, ramaddr);
        end
        if (ihit) early++;
        tick();
        if (ihit) early++;
        tick();
        if (ihit) early++;
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        tick();
        checks++;
        if (ihit !== 1'b1 || iload !== 32'hDEADBEEF || dhit !== 1'b0) begin
            failures++;
            $display("FAIL fetch_hit: ihit=%b iload=%h dhit=%b expected 1 deadbeef 0", ihit, iload, dhit);
        end
        checks++;
        if (early != 0 || ramREN !== 1'b0) begin
            failures++;
            $display("FAIL fetch_timing: early_hits=%0d ramREN=%b expected 0 0", early, ramREN);
        end
        iREN = 1'b0; ramstate = FREE;
        tick();
        checks++;
        if (ihit !== 1'b0) begin
            failures++;
            $display("FAIL fetch_pulse: ihit=%b expected 0", ihit);
        end
    endtask

    task automatic test_simultaneous();
        iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h100;
        ramstate = ACCESS; ramload = 32'h11111111;
        tick();
        checks++;
        if (ramaddr !== 32'h100 || ramREN !== 1'b1) begin
            failures++;
            $display("FAIL simul_first_addr: ramaddr=%h ramREN=%b expected 00000100 1", ramaddr, ramREN);
        end
        tick();
        checks++;
        if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'h11111111) begin
            failures++;
            $display("FAIL simul_dhit: dhit=%b ihit=%b dload=%h expected 1 0 11111111", dhit, ihit, dload);
        end
        dREN = 1'b0;
        tick();
        tick();
        checks++;
        if (ramaddr !== 32'h40 || ramREN !== 1'b1) begin
            failures++;
            $display("FAIL simul_second_addr: ramaddr=%h ramREN=%b expected 00000040 1", ramaddr, ramREN);
        end
        ramload = 32'h22222222;
        tick();
        checks++;
        if (ihit !== 1'b1 || dhit !== 1'b0 || iload !== 32'h22222222) begin
            failures++;
            $display("FAIL simul_ihit: ihit=%b dhit=%b iload=%h expected 1 0 22222222", ihit, dhit, iload);
        end
        iREN = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        int         n       = 0;
        int         illegal = 0;
        logic [5:0] pat     = '0;
        iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h180;
        ramstate = ACCESS; ramload = 32'hA5A5A5A5;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (ihit && dhit) illegal++;
            if (ramREN && ramWEN) illegal++;
            if (ihit || dhit) begin
                if (n < 6) pat[n] = ihit;
                n++;
            end
        end
        iREN = 1'b0; dREN = 1'b0;
        tick();
        checks++;
        if (n != 6) begin
            failures++;
            $display("FAIL starve_count: hits=%0d expected 6", n);
        end
        checks++;
        if (pat !== 6'b010000) begin
            failures++;
            $display("FAIL starve_order: pattern=%b expected 010000 (bit i set = hit i was fetch)", pat);
        end
        checks++;
        if (illegal != 0) begin
            failures++;
            $display("FAIL starve_exclusive: violations=%0d expected 0", illegal);
        end
    endtask

    task automatic test_write();
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h200; dstore = 32'h1234;
        ramstate = ACCESS; ramload = 32'hFFFF0000;
        tick();
        checks++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1234 || ramaddr !== 32'h200) begin
            failures++;
            $display("FAIL write_grant: ramWEN=%b ramREN=%b ramstore=%h ramaddr=%h expected 1 0 00001234 00000200",
                     ramWEN, ramREN, ramstore, ramaddr);
        end
        tick();
        checks++;
        if (dhit !== 1'b1 || dload !== 32'hA5A5A5A5 || ramWEN !== 1'b0) begin
            failures++;
            $display("FAIL write_done: dhit=%b dload=%h ramWEN=%b expected 1 a5a5a5a5 0", dhit, dload, ramWEN);
        end
        dWEN = 1'b0; dREN = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int dropped = 0;
        dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (ramREN !== 1'b1 || dhit !== 1'b0) dropped++;
        end
        checks++;
        if (dropped != 0) begin
            failures++;
            $display("FAIL timeout_hold: bad_grant_cycles=%0d expected 0", dropped);
        end
        tick();
        checks++;
        if (ramREN !== 1'b0 || dhit !== 1'b1 || dload !== 32'h0 || err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_fault: ramREN=%b dhit=%b dload=%h err=%b expected 0 1 00000000 1",
                     ramREN, dhit, dload, err);
        end
        dREN = 1'b0;
        tick();
        tick();
        checks++;
        if (err !== 1'b1 || dhit !== 1'b0) begin
            failures++;
            $display("FAIL timeout_sticky: err=%b dhit=%b expected 1 0", err, dhit);
        end
    endtask

    task automatic test_reset_mid_grant();
        int stray = 0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL rst_clears_err: err=%b expected 0", err);
        end
        iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY;
        tick();
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin
            failures++;
            $display("FAIL rst_pre_grant: ramREN=%b ramaddr=%h expected 1 00000080", ramREN, ramaddr);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0; iREN = 1'b0;
        checks++;
        if (ramREN !== 1'b0 || ihit !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL rst_abort: ramREN=%b ihit=%b err=%b expected 0 0 0", ramREN, ihit, err);
        end
        ramstate = ACCESS;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ihit || ramREN) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL rst_no_hit: stray_cycles=%0d expected 0", stray);
        end
        iREN = 1'b1; iaddr = 32'h84; ramload = 32'h5555AAAA;
        tick();
        tick();
        checks++;
        if (ihit !== 1'b1 || iload !== 32'h5555AAAA) begin
            failures++;
            $display("FAIL rst_then_fetch: ihit=%b iload=%h expected 1 5555aaaa", ihit, iload);
        end
        iREN = 1'b0;
        tick();
    endtask

    task automatic test_ram_error();
        dREN = 1'b1; daddr = 32'h3C0; ramstate = ACCESS; ramload = 32'h77777777;
        tick();
        tick();
        checks++;
        if (dhit !== 1'b1 || dload !== 32'h77777777 || err !== 1'b0) begin
            failures++;
            $display("FAIL err_pre_read: dhit=%b dload=%h err=%b expected 1 77777777 0", dhit, dload, err);
        end
        tick();
        ramstate = ERROR;
        tick();
        checks++;
        if (ramREN !== 1'b1) begin
            failures++;
            $display("FAIL err_grant: ramREN=%b expected 1", ramREN);
        end
        tick();
        checks++;
        if (dhit !== 1'b1 || dload !== 32'h0 || err !== 1'b1 || ramREN !== 1'b0) begin
            failures++;
            $display("FAIL err_fault: dhit=%b dload=%h err=%b ramREN=%b expected 1 00000000 1 0",
                     dhit, dload, err, ramREN);
        end
        dREN = 1'b0; ramstate = FREE;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_starvation();
        test_write();
        test_timeout();
        test_reset_mid_grant();
        test_ram_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
